// File: rtl/cci_mpf_shim_c0_arbiter.sv
// Two-requester round-robin arbiter for the CCI c0 read channel. It tracks per-requester credits and routes responses back by tag MSB.
// Defining MPF_C0_ARB_STATS_EN adds the grant0_cnt/grant1_cnt statistics ports.
module cci_mpf_shim_c0_arbiter #(
  parameter int ADDR_WIDTH      = 42,
  parameter int MDATA_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rq0_valid,
  input  logic [ADDR_WIDTH-1:0]  rq0_addr,
  input  logic [MDATA_WIDTH-2:0] rq0_mdata,
  output logic                   rq0_almfull,
  input  logic                   rq1_valid,
  input  logic [ADDR_WIDTH-1:0]  rq1_addr,
  input  logic [MDATA_WIDTH-2:0] rq1_mdata,
  output logic                   rq1_almfull,
  output logic                   fiu_valid,
  output logic [ADDR_WIDTH-1:0]  fiu_addr,
  output logic [MDATA_WIDTH-1:0] fiu_mdata,
  input  logic                   fiu_almfull,
  input  logic                   rsp_valid,
  input  logic [MDATA_WIDTH-1:0] rsp_mdata,
  output logic                   rsp0_valid,
  output logic [MDATA_WIDTH-2:0] rsp0_mdata,
  output logic                   rsp1_valid,
  output logic [MDATA_WIDTH-2:0] rsp1_mdata,
  output logic                   err_overflow
`ifdef MPF_C0_ARB_STATS_EN
  ,
  output logic [31:0]            grant0_cnt,
  output logic [31:0]            grant1_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam int EW = ADDR_WIDTH + MDATA_WIDTH - 1;

  logic [EW-1:0] fifo [2][4];
  logic [1:0]    rd_ptr [2];
  logic [1:0]    wr_ptr [2];
  logic [2:0]    occ [2];
  logic [CW-1:0] outst [2];
  logic          prio;

  logic          req_valid [2];
  logic [EW-1:0] req_entry [2];
  logic [EW-1:0] head [2];
  logic          elig [2];
  logic          grant [2];
  logic          push [2];
  logic          dec [2];
  logic [2:0]    occ_next [2];
  logic [CW-1:0] outst_next [2];

  // prio names the requester that wins when both are eligible
  always_comb begin
    req_valid[0] = rq0_valid;
    req_valid[1] = rq1_valid;
    req_entry[0] = {rq0_addr, rq0_mdata};
    req_entry[1] = {rq1_addr, rq1_mdata};
    for (int r = 0; r < 2; r++) begin
      head[r] = fifo[r][rd_ptr[r]];
      elig[r] = (occ[r] != 3'd0) && (outst[r] < MAX_CNT);
      push[r] = req_valid[r] && (occ[r] != 3'd4);
      dec[r]  = rsp_valid && (rsp_mdata[MDATA_WIDTH-1] == (r == 1));
    end
    grant[0] = !fiu_almfull && elig[0] && (!elig[1] || !prio);
    grant[1] = !fiu_almfull && elig[1] && (!elig[0] || prio);
    for (int r = 0; r < 2; r++) begin
      occ_next[r] = occ[r] + {2'b00, push[r]} - {2'b00, grant[r]};
      if (grant[r] && !dec[r])
        outst_next[r] = outst[r] + 1'b1;
      else if (!grant[r] && dec[r] && (outst[r] != '0))
        outst_next[r] = outst[r] - 1'b1;
      else
        outst_next[r] = outst[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        if (push[r])
          fifo[r][wr_ptr[r]] <= req_entry[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        rd_ptr[r] <= '0;
        wr_ptr[r] <= '0;
        occ[r]    <= '0;
        outst[r]  <= '0;
      end
      prio         <= 1'b0;
      err_overflow <= 1'b0;
      fiu_valid    <= 1'b0;
      fiu_addr     <= '0;
      fiu_mdata    <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_mdata   <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_mdata   <= '0;
      rq0_almfull  <= 1'b0;
      rq1_almfull  <= 1'b0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r])
          wr_ptr[r] <= wr_ptr[r] + 2'd1;
        if (grant[r])
          rd_ptr[r] <= rd_ptr[r] + 2'd1;
        if (req_valid[r] && (occ[r] == 3'd4))
          err_overflow <= 1'b1;
        occ[r]   <= occ_next[r];
        outst[r] <= outst_next[r];
      end
      // After a grant, priority passes to the other requester
      if (grant[0] || grant[1])
        prio <= grant[0];
      fiu_valid <= grant[0] || grant[1];
      if (grant[1]) begin
        fiu_addr  <= head[1][EW-1 -: ADDR_WIDTH];
        fiu_mdata <= {1'b1, head[1][MDATA_WIDTH-2:0]};
      end else if (grant[0]) begin
        fiu_addr  <= head[0][EW-1 -: ADDR_WIDTH];
        fiu_mdata <= {1'b0, head[0][MDATA_WIDTH-2:0]};
      end
      rsp0_valid  <= rsp_valid && !rsp_mdata[MDATA_WIDTH-1];
      rsp1_valid  <= rsp_valid && rsp_mdata[MDATA_WIDTH-1];
      rsp0_mdata  <= rsp_mdata[MDATA_WIDTH-2:0];
      rsp1_mdata  <= rsp_mdata[MDATA_WIDTH-2:0];
      rq0_almfull <= (occ_next[0] >= 3'd2) || (outst_next[0] == MAX_CNT);
      rq1_almfull <= (occ_next[1] >= 3'd2) || (outst_next[1] == MAX_CNT);
    end
  end

`ifdef MPF_C0_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      grant0_cnt <= grant0_cnt + 32'(grant[0]);
      grant1_cnt <= grant1_cnt + 32'(grant[1]);
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_shim_c0_arbiter.sv
// Self-checking bench for cci_mpf_shim_c0_arbiter: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_cci_mpf_shim_c0_arbiter;

  localparam int AW   = 42;
  localparam int MW   = 16;
  localparam int MAXO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
  logic [MW-2:0] rq0_mdata = '0, rq1_mdata = '0;
  logic rq0_almfull, rq1_almfull;
  logic fiu_valid;
  logic [AW-1:0] fiu_addr;
  logic [MW-1:0] fiu_mdata;
  logic fiu_almfull = 1'b0;
  logic rsp_valid = 1'b0;
  logic [MW-1:0] rsp_mdata = '0;
  logic rsp0_valid, rsp1_valid;
  logic [MW-2:0] rsp0_mdata, rsp1_mdata;
  logic err_overflow;
`ifdef MPF_C0_ARB_STATS_EN
  logic [31:0] grant0_cnt, grant1_cnt;
`endif

  always #5 clk = ~clk;

  cci_mpf_shim_c0_arbiter #(.ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_addr(rq0_addr), .rq0_mdata(rq0_mdata), .rq0_almfull(rq0_almfull),
    .rq1_valid(rq1_valid), .rq1_addr(rq1_addr), .rq1_mdata(rq1_mdata), .rq1_almfull(rq1_almfull),
    .fiu_valid(fiu_valid), .fiu_addr(fiu_addr), .fiu_mdata(fiu_mdata), .fiu_almfull(fiu_almfull),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
    .rsp0_valid(rsp0_valid), .rsp0_mdata(rsp0_mdata),
    .rsp1_valid(rsp1_valid), .rsp1_mdata(rsp1_mdata),
    .err_overflow(err_overflow)
`ifdef MPF_C0_ARB_STATS_EN
    , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: per-requester queues, credit counts, last-granted requester
  logic [56:0] mq0[$];
  logic [56:0] mq1[$];
  int mOut0, mOut1, mLast;
  bit modelReady = 0;
  bit eFiuValid, eRsp0Valid, eRsp1Valid, eAlm0, eAlm1, eErr;
  logic [AW-1:0] eFiuAddr;
  logic [MW-1:0] eFiuMdata;
  logic [MW-2:0] eRspMdata;
  longint eG0, eG1;

  initial begin
    forever begin : mdl
      int win;
      bit el0, el1, full0, full1;
      logic [56:0] ent;
      @(posedge clk);
      if (reset) begin
        mq0.delete(); mq1.delete();
        mOut0 = 0; mOut1 = 0; mLast = 1;
        eFiuValid = 0; eRsp0Valid = 0; eRsp1Valid = 0;
        eAlm0 = 0; eAlm1 = 0; eErr = 0; eG0 = 0; eG1 = 0;
        modelReady = 1;
      end else begin
        win = -1;
        el0 = (mq0.size() > 0) && (mOut0 < MAXO);
        el1 = (mq1.size() > 0) && (mOut1 < MAXO);
        if (!fiu_almfull) begin
          if (el0 && el1) win = 1 - mLast;
          else if (el0) win = 0;
          else if (el1) win = 1;
        end
        full0 = (mq0.size() == 4);
        full1 = (mq1.size() == 4);
        eFiuValid = (win >= 0);
        if (win == 0) begin
          ent = mq0.pop_front();
          eFiuAddr = ent[56:15]; eFiuMdata = {1'b0, ent[14:0]};
          mOut0++; mLast = 0; eG0++;
        end else if (win == 1) begin
          ent = mq1.pop_front();
          eFiuAddr = ent[56:15]; eFiuMdata = {1'b1, ent[14:0]};
          mOut1++; mLast = 1; eG1++;
        end
        if (rq0_valid) begin
          if (full0) eErr = 1; else mq0.push_back({rq0_addr, rq0_mdata});
        end
        if (rq1_valid) begin
          if (full1) eErr = 1; else mq1.push_back({rq1_addr, rq1_mdata});
        end
        if (rsp_valid && rsp_mdata[15] && mOut1 > 0) mOut1--;
        if (rsp_valid && !rsp_mdata[15] && mOut0 > 0) mOut0--;
        eRsp0Valid = rsp_valid && !rsp_mdata[15];
        eRsp1Valid = rsp_valid && rsp_mdata[15];
        eRspMdata = rsp_mdata[14:0];
        eAlm0 = (mq0.size() >= 2) || (mOut0 == MAXO);
        eAlm1 = (mq1.size() >= 2) || (mOut1 == MAXO);
      end
    end
  end

  // Per-cycle comparison against the model, plus grant observation for the directed checks
  int fiuCount = 0;
  int grantLog[$];
  initial begin
    forever begin
      @(negedge clk);
      if (modelReady) begin
        checkOutput("fiu_valid", fiu_valid, eFiuValid);
        if (eFiuValid) begin
          checkOutput("fiu_addr", fiu_addr, eFiuAddr);
          checkOutput("fiu_mdata", fiu_mdata, eFiuMdata);
        end
        checkOutput("rsp0_valid", rsp0_valid, eRsp0Valid);
        checkOutput("rsp1_valid", rsp1_valid, eRsp1Valid);
        if (eRsp0Valid) checkOutput("rsp0_mdata", rsp0_mdata, eRspMdata);
        if (eRsp1Valid) checkOutput("rsp1_mdata", rsp1_mdata, eRspMdata);
        checkOutput("rq0_almfull", rq0_almfull, eAlm0);
        checkOutput("rq1_almfull", rq1_almfull, eAlm1);
        checkOutput("err_overflow", err_overflow, eErr);
`ifdef MPF_C0_ARB_STATS_EN
        checkOutput("grant0_cnt", grant0_cnt, eG0[31:0]);
        checkOutput("grant1_cnt", grant1_cnt, eG1[31:0]);
`endif
        if (fiu_valid === 1'b1) begin
          fiuCount++;
          grantLog.push_back(int'(fiu_mdata[15]));
        end
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [MW-2:0] m0,
                               input logic v1, input logic [AW-1:0] a1, input logic [MW-2:0] m1,
                               input logic alm, input logic rv, input logic [MW-1:0] rm);
    rq0_valid = v0; rq0_addr = a0; rq0_mdata = m0;
    rq1_valid = v1; rq1_addr = a1; rq1_mdata = m1;
    fiu_almfull = alm; rsp_valid = rv; rsp_mdata = rm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic alm);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, alm, 0, '0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    idle(1, 0);
    reset = 1'b0;
  endtask

  initial begin
    idle(2, 0);
    reset = 1'b0;
    checkOutput("reset_fiu_valid", fiu_valid, 0);
    checkOutput("reset_rq0_almfull", rq0_almfull, 0);
    checkOutput("reset_err_overflow", err_overflow, 0);
    checkOutput("reset_rsp1_valid", rsp1_valid, 0);

    // Round-robin with both requesters busy
    fiuCount = 0; grantLog.delete();
    for (int i = 0; i < 8; i++)
      applyStimulus(1, AW'(42'h100 + i), 15'(i), 1, AW'(42'h200 + i), 15'(16'h40 + i),
                    0, i > 0, (i % 2 == 1) ? 16'h0000 : 16'h8000);
    idle(12, 0);
    checkOutput("rr_enough_grants", grantLog.size() >= 8, 1);
    for (int i = 0; i < 8 && i < grantLog.size(); i++)
      checkOutput($sformatf("rr_order_%0d", i), grantLog[i], i % 2);

    // Credit exhaustion on requester 0
    pulseReset();
    fiuCount = 0;
    for (int i = 0; i < 64; i++) applyStimulus(1, AW'(i), 15'(i), 0, '0, '0, 0, 0, '0);
    applyStimulus(1, 42'd100, 15'd100, 0, '0, '0, 0, 0, '0);
    idle(6, 0);
    checkOutput("credit_grant_count", fiuCount, 64);
    checkOutput("credit_rq0_almfull", rq0_almfull, 1);
    applyStimulus(0, '0, '0, 0, '0, '0, 0, 1, 16'h0000);
    checkOutput("credit_no_grant_on_rsp", fiu_valid, 0);
    idle(1, 0);
    checkOutput("credit_resume_valid", fiu_valid, 1);
    checkOutput("credit_resume_addr", fiu_addr, 42'd100);

    // FIU stall with two entries per requester
    pulseReset();
    fiuCount = 0;
    applyStimulus(1, 42'h10, 15'h1, 1, 42'h20, 15'h2, 1, 0, '0);
    applyStimulus(1, 42'h11, 15'h3, 1, 42'h21, 15'h4, 1, 0, '0);
    idle(8, 1);
    checkOutput("stall_no_valid", fiuCount, 0);
    idle(1, 0);
    checkOutput("stall_resume_valid", fiu_valid, 1);
    checkOutput("stall_resume_mdata", fiu_mdata, 16'h0001);
    idle(1, 0);
    checkOutput("stall_second_mdata", fiu_mdata, 16'h8002);

    // Response routing
    applyStimulus(0, '0, '0, 0, '0, '0, 0, 1, 16'h8005);
    checkOutput("route_rsp1_valid", rsp1_valid, 1);
    checkOutput("route_rsp1_mdata", rsp1_mdata, 15'h0005);
    checkOutput("route_rsp0_valid", rsp0_valid, 0);
    idle(4, 0);

    // Overflow
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, AW'(i), 15'(i), 0, '0, '0, 1, 0, '0);
    checkOutput("ovf_before_5th", err_overflow, 0);
    applyStimulus(1, 42'd4, 15'd4, 0, '0, '0, 1, 0, '0);
    checkOutput("ovf_after_5th", err_overflow, 1);
    idle(6, 0);
    checkOutput("ovf_sticky", err_overflow, 1);
    pulseReset();
    checkOutput("ovf_cleared", err_overflow, 0);

    // Reset with queued requests
    for (int i = 0; i < 3; i++) applyStimulus(1, AW'(i + 50), 15'(i), 0, '0, '0, 1, 0, '0);
    pulseReset();
    fiuCount = 0;
    idle(4, 0);
    checkOutput("rst_no_valid", fiuCount, 0);
    checkOutput("rst_rq0_almfull", rq0_almfull, 0);
    applyStimulus(1, 42'h77, 15'h7, 1, 42'h88, 15'h8, 0, 0, '0);
    idle(1, 0);
    checkOutput("rst_first_valid", fiu_valid, 1);
    checkOutput("rst_first_mdata", fiu_mdata, 16'h0007);
    idle(1, 0);
    checkOutput("rst_second_mdata", fiu_mdata, 16'h8008);
    idle(3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
